// File: rtl/matrix_input_parser_if.sv
`default_nettype none
// ============================================================================
// Module   : matrix_input_parser_if
// Purpose  : Token-in / matrix-out bus between the number decoder, the main
//            FSM control pulses and the matrix parser.
//            mat_out layout (matrix_t, 207 bits):
//              [206]     is_valid
//              [205:203] rows
//              [202:200] cols
//              [199:0]   cells[r][c] at bit (r*40 + c*8), 8-bit signed
// Revision : 1.0 - initial release
// ============================================================================
interface matrix_input_parser_if;
  logic         start;
  logic         abort;
  logic         tok_valid;
  logic [7:0]   tok_data;
  logic         tok_ready;
  logic         busy;
  logic         mat_valid;
  logic [206:0] mat_out;
  logic [4:0]   elem_cnt;
  logic         err;
  logic [1:0]   err_code;

  // Parser side
  modport slave (
    input  start, abort, tok_valid, tok_data,
    output tok_ready, busy, mat_valid, mat_out, elem_cnt, err, err_code
  );

  // Token source / controller side
  modport master (
    output start, abort, tok_valid, tok_data,
    input  tok_ready, busy, mat_valid, mat_out, elem_cnt, err, err_code
  );
endinterface
`default_nettype wire

// File: rtl/matrix_input_parser.sv
`default_nettype none
// ============================================================================
// Module   : matrix_input_parser
// Purpose  : Builds one matrix from a token stream: rows, cols, then
//            rows*cols elements in row-major order. Validates dimensions and
//            element range and aborts on inactivity timeout.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_input_parser #(
  parameter int                 MAX_ROWS       = 5,
  parameter int                 MAX_COLS       = 5,
  parameter logic signed [7:0]  VAL_MIN        = 8'sd0,
  parameter logic signed [7:0]  VAL_MAX        = 8'sd9,
  parameter int                 TIMEOUT_CYCLES = 1_000_000_000
) (
  input  wire logic              clk,
  input  wire logic              rst,
  matrix_input_parser_if.slave   bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_DIM   = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_TMO   = 2'd3;

  typedef struct packed {
    logic                  is_valid;
    logic [2:0]            rows;
    logic [2:0]            cols;
    logic [4:0][4:0][7:0]  cells;
  } matrix_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GET_ROWS  = 3'd1,
    S_GET_COLS  = 3'd2,
    S_GET_ELEMS = 3'd3,
    S_DONE      = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  state_t           state_q, state_d;
  matrix_t          mat_q, mat_d;
  logic [4:0]       elem_cnt_q, elem_cnt_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [2:0]       row_q, row_d;
  logic [2:0]       col_q, col_d;

  logic              tok_ready;
  logic              accept;
  logic signed [7:0] tok_s;

  assign tok_s     = $signed(bus.tok_data);
  assign tok_ready = (state_q == S_GET_ROWS) || (state_q == S_GET_COLS) ||
                     (state_q == S_GET_ELEMS);
  assign accept    = bus.tok_valid && tok_ready;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mat_q      <= '0;
      elem_cnt_q <= '0;
      err_code_q <= ERR_NONE;
      tmo_cnt_q  <= '0;
      row_q      <= '0;
      col_q      <= '0;
    end else begin
      state_q    <= state_d;
      mat_q      <= mat_d;
      elem_cnt_q <= elem_cnt_d;
      err_code_q <= err_code_d;
      tmo_cnt_q  <= tmo_cnt_d;
      row_q      <= row_d;
      col_q      <= col_d;
    end
  end

  // Next-state logic: abort beats accept, accept beats timeout
  always_comb begin
    state_d    = state_q;
    mat_d      = mat_q;
    elem_cnt_d = elem_cnt_q;
    err_code_d = err_code_q;
    tmo_cnt_d  = tmo_cnt_q;
    row_d      = row_q;
    col_d      = col_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          mat_d      = '0;
          elem_cnt_d = '0;
          err_code_d = ERR_NONE;
          tmo_cnt_d  = '0;
          row_d      = '0;
          col_d      = '0;
          state_d    = S_GET_ROWS;
        end
      end

      S_GET_ROWS, S_GET_COLS, S_GET_ELEMS: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (accept) begin
          tmo_cnt_d = '0;
          if (state_q == S_GET_ROWS) begin
            if (tok_s >= 1 && tok_s <= MAX_ROWS) begin
              mat_d.rows = bus.tok_data[2:0];
              state_d    = S_GET_COLS;
            end else begin
              err_code_d = ERR_DIM;
              state_d    = S_FAIL;
            end
          end else if (state_q == S_GET_COLS) begin
            if (tok_s >= 1 && tok_s <= MAX_COLS) begin
              mat_d.cols = bus.tok_data[2:0];
              state_d    = S_GET_ELEMS;
            end else begin
              err_code_d = ERR_DIM;
              state_d    = S_FAIL;
            end
          end else begin
            if (tok_s >= VAL_MIN && tok_s <= VAL_MAX) begin
              mat_d.cells[row_q][col_q] = bus.tok_data;
              elem_cnt_d = elem_cnt_q + 5'd1;
              if (col_q == mat_q.cols - 3'd1) begin
                col_d = '0;
                if (row_q == mat_q.rows - 3'd1) begin
                  mat_d.is_valid = 1'b1;
                  state_d        = S_DONE;
                end else begin
                  row_d = row_q + 3'd1;
                end
              end else begin
                col_d = col_q + 3'd1;
              end
            end else begin
              err_code_d = ERR_RANGE;
              state_d    = S_FAIL;
            end
          end
        end else if (tmo_cnt_q == CNT_LAST) begin
          err_code_d = ERR_TMO;
          state_d    = S_FAIL;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
      end

      S_DONE, S_FAIL: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.tok_ready = tok_ready;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.mat_valid = (state_q == S_DONE);
  assign bus.err       = (state_q == S_FAIL);
  assign bus.mat_out   = mat_q;
  assign bus.elem_cnt  = elem_cnt_q;
  assign bus.err_code  = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_input_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_input_parser
// Purpose  : Directed self-checking bench for matrix_input_parser.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_input_parser;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  matrix_input_parser_if bus ();

  matrix_input_parser #(.TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Presents a token and waits (bounded) until it is accepted; tok_valid stays high.
  task automatic send_tok(input logic [7:0] v);
    int waited;
    waited = 0;
    bus.tok_valid = 1'b1;
    bus.tok_data  = v;
    while (!bus.tok_ready && waited < 50) begin
      tick();
      waited++;
    end
    n_checks++;
    if (bus.tok_ready !== 1'b1) begin n_fail++; $display("FAIL tok_ready_wait: tok_ready=%b expected 1", bus.tok_ready); end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_checks++;
    if ({bus.busy, bus.tok_ready, bus.mat_valid, bus.err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {bus.busy, bus.tok_ready, bus.mat_valid, bus.err});
    end
    n_checks++;
    if (bus.mat_out !== 207'd0) begin n_fail++; $display("FAIL reset_mat_out: got %h expected 0", bus.mat_out); end
    n_checks++;
    if ({bus.elem_cnt, bus.err_code} !== 7'd0) begin
      n_fail++; $display("FAIL reset_cnt_code: got %h expected 0", {bus.elem_cnt, bus.err_code});
    end
  endtask

  task automatic test_normal_2x3();
    logic [206:0] exp;
    exp = '0;
    exp[206] = 1'b1;
    exp[205:203] = 3'd2;
    exp[202:200] = 3'd3;
    exp[7:0]   = 8'd1; exp[15:8]  = 8'd2; exp[23:16] = 8'd3;
    exp[47:40] = 8'd4; exp[55:48] = 8'd5; exp[63:56] = 8'd6;
    do_start();
    n_checks++;
    if ({bus.busy, bus.tok_ready} !== 2'b11) begin n_fail++; $display("FAIL start_busy_ready: got %b expected 11", {bus.busy, bus.tok_ready}); end
    send_tok(8'd2); send_tok(8'd3);
    send_tok(8'd1); send_tok(8'd2); send_tok(8'd3);
    send_tok(8'd4); send_tok(8'd5);
    n_checks++;
    if (bus.mat_valid !== 1'b0) begin n_fail++; $display("FAIL early_mat_valid: got %b expected 0", bus.mat_valid); end
    send_tok(8'd6);
    bus.tok_valid = 1'b0;
    n_checks++;
    if (bus.mat_valid !== 1'b1) begin n_fail++; $display("FAIL done_mat_valid: got %b expected 1", bus.mat_valid); end
    n_checks++;
    if (bus.mat_out !== exp) begin n_fail++; $display("FAIL mat_2x3: got %h expected %h", bus.mat_out, exp); end
    n_checks++;
    if (bus.elem_cnt !== 5'd6) begin n_fail++; $display("FAIL elem_cnt_2x3: got %0d expected 6", bus.elem_cnt); end
    n_checks++;
    if (bus.tok_ready !== 1'b0) begin n_fail++; $display("FAIL done_tok_ready: got %b expected 0", bus.tok_ready); end
    tick();
    n_checks++;
    if ({bus.mat_valid, bus.busy} !== 2'b00) begin n_fail++; $display("FAIL after_done: got %b expected 00", {bus.mat_valid, bus.busy}); end
    n_checks++;
    if (bus.mat_out !== exp) begin n_fail++; $display("FAIL mat_hold: got %h expected %h", bus.mat_out, exp); end
  endtask

  // Drives rows (and optionally cols) and checks a bad-dimension failure.
  task automatic bad_dim(input logic [7:0] rows_tok, input bit use_cols,
                         input logic [7:0] cols_tok, input logic [2:0] exp_rows);
    do_start();
    send_tok(rows_tok);
    if (use_cols) send_tok(cols_tok);
    bus.tok_valid = 1'b0;
    n_checks++;
    if ({bus.err, bus.err_code} !== 3'b101) begin
      n_fail++; $display("FAIL bad_dim_err: rows_tok=%0d got err=%b code=%0d expected err=1 code=1", rows_tok, bus.err, bus.err_code);
    end
    n_checks++;
    if (bus.mat_out[205:200] !== {exp_rows, 3'd0}) begin
      n_fail++; $display("FAIL bad_dim_written: got %h expected %h", bus.mat_out[205:200], {exp_rows, 3'd0});
    end
    tick();
    n_checks++;
    if ({bus.err, bus.busy, bus.tok_ready, bus.err_code} !== 5'b00001) begin
      n_fail++; $display("FAIL bad_dim_after: got %b expected 00001", {bus.err, bus.busy, bus.tok_ready, bus.err_code});
    end
  endtask

  task automatic test_bad_dimension();
    bad_dim(8'd6, 1'b0, 8'd0, 3'd0);
    bad_dim(8'd0, 1'b0, 8'd0, 3'd0);
    bad_dim(8'd2, 1'b1, 8'hFF, 3'd2);
  endtask

  task automatic test_elem_range();
    bit saw_valid;
    saw_valid = 1'b0;
    do_start();
    send_tok(8'd1); send_tok(8'd2); send_tok(8'd9);
    send_tok(8'd10);
    bus.tok_valid = 1'b0;
    saw_valid = saw_valid | bus.mat_valid;
    n_checks++;
    if ({bus.err, bus.err_code} !== 3'b110) begin
      n_fail++; $display("FAIL range_err: got err=%b code=%0d expected err=1 code=2", bus.err, bus.err_code);
    end
    n_checks++;
    if (bus.mat_out[7:0] !== 8'd9) begin n_fail++; $display("FAIL range_cell00: got %0d expected 9", bus.mat_out[7:0]); end
    n_checks++;
    if (bus.mat_out[15:8] !== 8'd0) begin n_fail++; $display("FAIL range_cell01: got %0d expected 0", bus.mat_out[15:8]); end
    n_checks++;
    if (bus.elem_cnt !== 5'd1) begin n_fail++; $display("FAIL range_elem_cnt: got %0d expected 1", bus.elem_cnt); end
    tick();
    saw_valid = saw_valid | bus.mat_valid;
    n_checks++;
    if ({saw_valid, bus.mat_out[206]} !== 2'b00) begin
      n_fail++; $display("FAIL range_no_valid: got %b expected 00", {saw_valid, bus.mat_out[206]});
    end
  endtask

  task automatic test_timeout();
    bit early;
    early = 1'b0;
    do_start();
    send_tok(8'd2); send_tok(8'd2);
    bus.tok_valid = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      early = early | bus.err;
    end
    n_checks++;
    if (early !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b expected 0", early); end
    tick();
    n_checks++;
    if ({bus.err, bus.err_code} !== 3'b111) begin
      n_fail++; $display("FAIL timeout_err: got err=%b code=%0d expected err=1 code=3", bus.err, bus.err_code);
    end
    tick();
    // Accept on the timeout cycle suppresses the error
    do_start();
    send_tok(8'd2); send_tok(8'd2);
    bus.tok_valid = 1'b0;
    for (int i = 1; i <= 15; i++) tick();
    bus.tok_valid = 1'b1;
    bus.tok_data  = 8'd5;
    tick();
    bus.tok_valid = 1'b0;
    n_checks++;
    if ({bus.err, bus.busy, bus.elem_cnt, bus.err_code} !== {1'b0, 1'b1, 5'd1, 2'd0}) begin
      n_fail++; $display("FAIL timeout_suppress: got err=%b busy=%b cnt=%0d code=%0d expected 0 1 1 0",
                         bus.err, bus.busy, bus.elem_cnt, bus.err_code);
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask

  task automatic test_abort();
    do_start();
    send_tok(8'd3); send_tok(8'd3); send_tok(8'd1);
    bus.tok_data = 8'd2;
    bus.abort    = 1'b1;
    tick();
    bus.abort     = 1'b0;
    bus.tok_valid = 1'b0;
    n_checks++;
    if ({bus.busy, bus.tok_ready, bus.err, bus.mat_valid} !== 4'b0000) begin
      n_fail++; $display("FAIL abort_flags: got %b expected 0000", {bus.busy, bus.tok_ready, bus.err, bus.mat_valid});
    end
    n_checks++;
    if ({bus.elem_cnt, bus.err_code, bus.mat_out[206]} !== {5'd1, 2'd0, 1'b0}) begin
      n_fail++; $display("FAIL abort_state: got cnt=%0d code=%0d vld=%b expected 1 0 0", bus.elem_cnt, bus.err_code, bus.mat_out[206]);
    end
    n_checks++;
    if (bus.mat_out[15:8] !== 8'd0) begin n_fail++; $display("FAIL abort_not_consumed: got %0d expected 0", bus.mat_out[15:8]); end
    // start with abort in IDLE is ignored
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL start_abort_idle: busy=%b expected 0", bus.busy); end
    do_start();
    send_tok(8'd1); send_tok(8'd1); send_tok(8'd7);
    bus.tok_valid = 1'b0;
    n_checks++;
    if ({bus.mat_valid, bus.mat_out[206:200], bus.mat_out[7:0]} !== {1'b1, 1'b1, 3'd1, 3'd1, 8'd7}) begin
      n_fail++; $display("FAIL abort_then_1x1: got %b %h %0d expected 1 49 7", bus.mat_valid, bus.mat_out[206:200], bus.mat_out[7:0]);
    end
    n_checks++;
    if (bus.mat_out[199:8] !== 192'd0) begin n_fail++; $display("FAIL 1x1_other_cells: got %h expected 0", bus.mat_out[199:8]); end
    tick();
  endtask

  task automatic test_reset_mid_parse();
    do_start();
    send_tok(8'd5); send_tok(8'd5);
    send_tok(8'd1); send_tok(8'd2); send_tok(8'd3); send_tok(8'd4);
    bus.tok_valid = 1'b0;
    n_checks++;
    if (bus.elem_cnt !== 5'd4) begin n_fail++; $display("FAIL mid_elem_cnt: got %0d expected 4", bus.elem_cnt); end
    do_start();
    n_checks++;
    if ({bus.busy, bus.elem_cnt, bus.mat_out[31:24]} !== {1'b1, 5'd4, 8'd4}) begin
      n_fail++; $display("FAIL start_while_busy: got busy=%b cnt=%0d c03=%0d expected 1 4 4", bus.busy, bus.elem_cnt, bus.mat_out[31:24]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({bus.busy, bus.elem_cnt} !== 6'd0) begin n_fail++; $display("FAIL mid_rst_flags: got %h expected 0", {bus.busy, bus.elem_cnt}); end
    n_checks++;
    if (bus.mat_out !== 207'd0) begin n_fail++; $display("FAIL mid_rst_mat: got %h expected 0", bus.mat_out); end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.tok_valid = 1'b0;
    bus.tok_data  = 8'd0;
    test_reset();
    test_normal_2x3();
    test_bad_dimension();
    test_elem_range();
    test_timeout();
    test_abort();
    test_reset_mid_parse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matrix_input_parser.md
Name: matrix_input_parser

Overview:
- Assembles one `matrix_t` from a stream of decoded numeric tokens.
- Token order: rows, then cols, then rows*cols elements in row-major order.
- Sits directly upstream of matrix storage. Tokens come from the UART ASCII-to-number decoder; the completed matrix goes to the storage write port.
- Checks dimensions and element range, and enforces an inactivity timeout. In STATE_INPUT it is driven by the main FSM via start/abort.

Parameters:
- MAX_ROWS, 5, upper limit on the rows token (from `project_pkg`).
- MAX_COLS, 5, upper limit on the cols token (from `project_pkg`).
- VAL_MIN, 8'sd0, minimum legal element value (`DEFAULT_VAL_MIN`).
- VAL_MAX, 8'sd9, maximum legal element value (`DEFAULT_VAL_MAX`).
- TIMEOUT_CYCLES, 1_000_000_000, idle cycles allowed between accepted tokens (10 s at `SYS_CLK_FREQ`). Counter width is `$clog2(TIMEOUT_CYCLES+1)`.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a new parse. Ignored while busy=1.
- abort  in  1  returns to IDLE with no result and no error.
- tok_valid  in  1  token present.
- tok_data  in  8  signed token value (`matrix_element_t`).
- tok_ready  out  1  parser can accept a token.
- busy  out  1  parse in progress.
- mat_valid  out  1  one-cycle pulse: mat_out holds a completed matrix.
- mat_out  out  207  `matrix_t` result.
- elem_cnt  out  5  number of elements accepted so far, for seven-segment progress display.
- err  out  1  one-cycle pulse on parse failure.
- err_code  out  2  failure cause: 0 none, 1 bad dimension, 2 element out of range, 3 timeout.

Behaviour:
- Interface: one clock domain (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - state = IDLE.
  - tok_ready, busy, mat_valid, err = 0.
  - mat_out = all zero (is_valid=0).
  - elem_cnt = 0, err_code = 0.
  - Timeout counter = 0.
- States: IDLE, GET_ROWS, GET_COLS, GET_ELEMS, DONE, FAIL.
- Handshake:
  - A token is accepted on a cycle where tok_valid & tok_ready.
  - tok_ready = 1 exactly in GET_ROWS, GET_COLS and GET_ELEMS.
  - busy = 1 in every state except IDLE.
- IDLE + start:
  - mat_out cleared to all zero.
  - elem_cnt = 0, err_code = 0, timeout counter = 0.
  - Next state GET_ROWS.
- GET_ROWS, on accept:
  - Value in 1..MAX_ROWS: mat_out.rows = tok_data[2:0], next state GET_COLS.
  - Otherwise: err_code = 1, next state FAIL.
  - Negative values count as invalid.
- GET_COLS: same rule against 1..MAX_COLS, writing mat_out.cols. Next state GET_ELEMS.
- GET_ELEMS:
  - Each accepted value must satisfy VAL_MIN <= value <= VAL_MAX (signed compare). Otherwise err_code = 2, next state FAIL.
  - A legal value is written to cells[r][c].
  - Column index c increments; at c = cols-1 it wraps to 0 and r increments.
  - elem_cnt increments on each legal write.
  - Acceptance of the element at r = rows-1, c = cols-1 moves the FSM to DONE.
  - Cells outside rows x cols remain 0.
- DONE (one cycle):
  - mat_out.is_valid = 1, mat_valid = 1.
  - Next state IDLE.
  - mat_out holds its value until the next accepted start.
  - Latency: mat_valid asserts 1 cycle after the final token is accepted.
- FAIL (one cycle):
  - err = 1.
  - Next state IDLE.
  - err_code holds until the next start.
  - mat_out.is_valid stays 0.
- Timeout:
  - In the GET_* states the counter increments on each cycle with no accept, and clears on each accept.
  - When the counter reaches TIMEOUT_CYCLES-1: err_code = 3, next state FAIL.
  - An accept on the same cycle as the timeout wins: the counter clears and there is no error.
- Abort:
  - In any non-IDLE state: next state IDLE, no pulses.
  - mat_out.is_valid stays 0, err_code unchanged.
  - abort has priority over a simultaneous token accept and over timeout.
- Simultaneous start and abort in IDLE: abort wins and start is ignored.
- rst asserted mid-parse: all outputs return to their reset values on the next edge. Partial data is discarded.
- Bad dimension tokens are not written to mat_out.

Test Plan:
- Normal 2x3 parse: start; tokens 2,3,1,2,3,4,5,6 with tok_valid held high → mat_valid pulse 1 cycle after token "6"; rows=2, cols=3, cells[0]={1,2,3}, cells[1]={4,5,6}, all other cells 0, is_valid=1, elem_cnt=6.
- Bad dimension: start; tokens 6 (rows) → err pulse 1 cycle later, err_code=1, busy=0, tok_ready=0. Repeat the check with rows=0 and with cols=-1.
- Element out of range: start; tokens 1,2,9,10 → err, err_code=2, cells[0][0]=9 retained, mat_valid never asserts.
- Timeout with TIMEOUT_CYCLES=16: start, tokens 2,2, then idle → err asserts exactly 16 cycles after the last accept, err_code=3. A token presented on cycle 15 instead suppresses the error.
- Abort and back-pressure: start; tokens 3,3,1; abort held together with tok_valid → return to IDLE, no err, no mat_valid, token not consumed, tok_ready=0. A following start with a 1x1 matrix containing 7 → mat_valid, cells[0][0]=7.
- Reset mid-parse: after 4 elements of a 5x5 parse, assert rst for 1 cycle → mat_out=0, elem_cnt=0, busy=0. start while busy is ignored (verify with a second start during GET_ELEMS: elem_cnt is not cleared).
